// File: rtl/fetch_npc_unit.sv
// -----------------------------------------------------------------------------
// fetch_npc_unit
//
// Front end of the pipelined MIPS core. Holds the PC, presents it to a
// combinational instruction memory, selects the next PC (sequential, J/JAL,
// JR or taken BEQ) and drives the IF/ID pipeline register. Also keeps two
// wrapping event counters and a sticky JR-misalignment flag.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (overrides every other input)
//   imem_addr    current PC, address into instruction memory
//   imem_rdata   instruction word at imem_addr (same cycle)
//   stall        hold PC and IF/ID (load-use hazard)
//   redir_valid  a resolved control transfer is presented this cycle
//   s_npc        next-PC select: 00 seq, 01 BEQ, 10 J, 11 JR
//   redir_pc4    PC+4 of the redirecting instruction
//   instr_index  J/JAL 26-bit target field
//   imm16        BEQ 16-bit word offset
//   jr_target    forwarded rs value for JR
//   id_instr     IF/ID instruction register
//   id_pc4       IF/ID PC+4 register
//   id_valid     IF/ID holds a real (non-squashed) instruction
//   pc_misalign  sticky: a taken JR target had nonzero bits [1:0]
//   fetch_count  instructions latched into IF/ID (wraps)
//   flush_count  redirects taken (wraps)
// -----------------------------------------------------------------------------
module fetch_npc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [1:0]  s_npc,
   input  logic [31:0] redir_pc4,
   input  logic [25:0] instr_index,
   input  logic [15:0] imm16,
   input  logic [31:0] jr_target,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic        pc_misalign,
   output logic [31:0] fetch_count,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      N_NPC   = 2'b00,
      BEQ_NPC = 2'b01,
      J_NPC   = 2'b10,
      JR_NPC  = 2'b11
   } npc_sel_e;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] beq_offset;
   logic [31:0] redir_target;
   logic        redirect;
   logic        jr_misaligned;
   npc_sel_e    sel;

   assign sel       = npc_sel_e'(s_npc);
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;      // wraps 32'hFFFF_FFFC -> 0

   // Sign-extended word offset, already shifted to a byte offset.
   assign beq_offset = {{14{imm16[15]}}, imm16, 2'b00};

   // A sequential select with redir_valid high is not a control transfer.
   assign redirect      = redir_valid && (sel != N_NPC);
   assign jr_misaligned = redirect && (sel == JR_NPC) && (jr_target[1:0] != 2'b00);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      redir_target = pc_plus4;
      unique case (sel)
         N_NPC:   redir_target = pc_plus4;
         BEQ_NPC: redir_target = redir_pc4 + beq_offset;
         J_NPC:   redir_target = {redir_pc4[31:28], instr_index, 2'b00};
         JR_NPC:  redir_target = {jr_target[31:2], 2'b00};
      endcase
   end

   // Priority: rst > redirect > stall > normal fetch.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         id_instr    <= NOP_WORD;
         id_pc4      <= 32'd0;
         id_valid    <= 1'b0;
         pc_misalign <= 1'b0;
         fetch_count <= 32'd0;
         flush_count <= 32'd0;
      end else if (redirect) begin
         // The one wrong-path instruction currently at imem_addr is dropped.
         pc          <= redir_target;
         id_instr    <= NOP_WORD;
         id_pc4      <= 32'd0;
         id_valid    <= 1'b0;
         flush_count <= flush_count + 32'd1;
         if (jr_misaligned)
            pc_misalign <= 1'b1;
      end else if (!stall) begin
         pc          <= pc_plus4;
         id_instr    <= imem_rdata;
         id_pc4      <= pc_plus4;
         id_valid    <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_npc_unit
//
// Self-checking bench for fetch_npc_unit. Each vector holds the inputs for one
// cycle plus the register state expected after that rising edge. Expected
// records are pushed to a scoreboard queue when stimulus is driven and popped
// and compared 1 ns after the edge. Instruction memory is a fixed function of
// the address so the expected id_instr follows from the expected id_pc4.
// -----------------------------------------------------------------------------
module tb_fetch_npc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redir_valid;
   logic [1:0]  s_npc;
   logic [31:0] redir_pc4;
   logic [25:0] instr_index;
   logic [15:0] imm16;
   logic [31:0] jr_target;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        pc_misalign;
   logic [31:0] fetch_count;
   logic [31:0] flush_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_npc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redir_valid (redir_valid),
      .s_npc       (s_npc),
      .redir_pc4   (redir_pc4),
      .instr_index (instr_index),
      .imm16       (imm16),
      .jr_target   (jr_target),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .id_valid    (id_valid),
      .pc_misalign (pc_misalign),
      .fetch_count (fetch_count),
      .flush_count (flush_count)
   );

   function automatic logic [31:0] im_word(logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   assign imem_rdata = im_word(imem_addr);

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        rv;
      logic [1:0]  sel;
      logic [31:0] rpc4;
      logic [25:0] idx;
      logic [15:0] imm;
      logic [31:0] jrt;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc4;
      logic [31:0] e_fc;
      logic [31:0] e_fl;
      logic        e_mis;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   vec_no = 0;

   function automatic vec_t mk(logic r, logic st, logic rv, logic [1:0] sel,
                               logic [31:0] rpc4, logic [25:0] idx,
                               logic [15:0] imm, logic [31:0] jrt,
                               logic [31:0] e_addr, logic e_valid,
                               logic [31:0] e_pc4, logic [31:0] e_fc,
                               logic [31:0] e_fl, logic e_mis);
      vec_t v;
      v.rst = r;  v.stall = st; v.rv = rv; v.sel = sel;
      v.rpc4 = rpc4; v.idx = idx; v.imm = imm; v.jrt = jrt;
      v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc4 = e_pc4;
      v.e_fc = e_fc; v.e_fl = e_fl; v.e_mis = e_mis;
      return v;
   endfunction

   // Plain sequential-fetch cycle with idle redirect fields.
   function automatic vec_t mk_n(logic [31:0] e_addr, logic [31:0] e_fc,
                                 logic [31:0] e_fl, logic e_mis);
      return mk(0, 0, 0, 2'b00, 32'h0, 26'h0, 16'h0, 32'h0,
                e_addr, 1'b1, e_addr, e_fc, e_fl, e_mis);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%h required=%h", name, vec_no, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      vec_t e;
      logic [31:0] e_instr;
      @(negedge clk);
      rst = v.rst; stall = v.stall; redir_valid = v.rv; s_npc = v.sel;
      redir_pc4 = v.rpc4; instr_index = v.idx; imm16 = v.imm; jr_target = v.jrt;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty vec=%0d", vec_no);
      end else begin
         e = sb.pop_front();
         // IF/ID holds the word fetched from (id_pc4 - 4), or the NOP word.
         e_instr = e.e_valid ? im_word(e.e_pc4 - 32'd4) : 32'h0;
         check("imem_addr",   imem_addr,   e.e_addr);
         check("id_valid",    {31'd0, id_valid}, {31'd0, e.e_valid});
         check("id_pc4",      id_pc4,      e.e_pc4);
         check("id_instr",    id_instr,    e_instr);
         check("fetch_count", fetch_count, e.e_fc);
         check("flush_count", flush_count, e.e_fl);
         check("pc_misalign", {31'd0, pc_misalign}, {31'd0, e.e_mis});
      end
      vec_no++;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; s_npc = 2'b00;
      redir_pc4 = '0; instr_index = '0; imm16 = '0; jr_target = '0;

      // Reset, free run, J, BEQ back/forward, misaligned JR.
      tbl.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
      tbl.push_back(mk_n(32'h3004, 1, 0, 0));
      tbl.push_back(mk_n(32'h3008, 2, 0, 0));
      tbl.push_back(mk_n(32'h300C, 3, 0, 0));
      tbl.push_back(mk(0, 0, 1, 2'b10, 32'h3010, 26'h0000C10, 0, 0, 32'h3040, 0, 0, 3, 1, 0));
      tbl.push_back(mk_n(32'h3044, 4, 1, 0));
      tbl.push_back(mk(0, 0, 1, 2'b01, 32'h3020, 0, 16'hFFFC, 0, 32'h3010, 0, 0, 4, 2, 0));
      tbl.push_back(mk(0, 0, 1, 2'b01, 32'h3020, 0, 16'h0003, 0, 32'h302C, 0, 0, 4, 3, 0));
      tbl.push_back(mk_n(32'h3030, 5, 3, 0));
      tbl.push_back(mk(0, 0, 1, 2'b11, 0, 0, 0, 32'h0000_4006, 32'h4004, 0, 0, 5, 4, 1));
      foreach (tbl[i]) apply(tbl[i]);

      // Sticky misalign flag survives 10 further fetch cycles.
      for (int k = 1; k <= 10; k++)
         apply(mk_n(32'h4004 + 32'(4 * k), 32'(5 + k), 4, 1));

      // Reset clears the flag; an aligned JR leaves it clear.
      apply(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 1, 2'b11, 0, 0, 0, 32'h0000_4008, 32'h4008, 0, 0, 0, 1, 0));
      apply(mk_n(32'h400C, 1, 1, 0));

      // Stall at pc=0x3008 for two cycles, then stall together with a J.
      apply(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 0));
      apply(mk_n(32'h3004, 1, 0, 0));
      apply(mk_n(32'h3008, 2, 0, 0));
      for (int k = 0; k < 2; k++)
         apply(mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h3008, 1, 32'h3008, 2, 0, 0));
      apply(mk(0, 1, 1, 2'b10, 32'h3010, 26'h0000C10, 0, 0, 32'h3040, 0, 0, 2, 1, 0));
      apply(mk_n(32'h3044, 3, 1, 0));

      // Reset during a redirect cycle discards the redirect.
      apply(mk(1, 0, 1, 2'b10, 32'h3010, 26'h0000C10, 0, 0, 32'h3000, 0, 0, 0, 0, 0));

      // redir_valid with sequential select is an ordinary fetch.
      apply(mk(0, 0, 1, 2'b00, 32'h5550, 26'h3FFFFFF, 16'h8000, 32'hFFFF_FFFF,
               32'h3004, 1, 32'h3004, 1, 0, 0));

      // JR to the top of the address space, then PC wraps to 0.
      apply(mk(0, 0, 1, 2'b11, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0, 1, 1, 1));
      apply(mk_n(32'h0000_0000, 2, 1, 1));
      apply(mk_n(32'h0000_0004, 3, 1, 1));

      // Stall with a sequential-select redir_valid still holds everything.
      apply(mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 32'h0000_0004, 1, 32'h0000_0004, 3, 1, 1));

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- Front end of the pipelined MIPS core; the consumer of the decoder's s_npc selection.
- Holds the PC and presents it to instruction memory.
- Computes the next PC: sequential, J/JAL, JR or taken BEQ.
- Drives the IF/ID pipeline register, with stall, squash-on-redirect and two wrapping event counters.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected into IF/ID on flush or reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  current PC (== pc register).
- imem_rdata  in  32  instruction word at imem_addr, same cycle (combinational IM).
- stall  in  1  hold PC and IF/ID (load-use hazard).
- redir_valid  in  1  a resolved control transfer is presented this cycle.
- s_npc  in  2  next-PC select: 2'b00 N_nPC, 2'b01 BEQ_nPC, 2'b10 J_nPC, 2'b11 JR_nPC.
- redir_pc4  in  32  PC+4 of the redirecting instruction.
- instr_index  in  26  J/JAL target field.
- imm16  in  16  BEQ offset field.
- jr_target  in  32  forwarded rs value for JR.
- id_instr  out  32  IF/ID instruction register.
- id_pc4  out  32  IF/ID PC+4 register.
- id_valid  out  1  IF/ID holds a real (non-squashed) instruction.
- pc_misalign  out  1  sticky: a JR target had nonzero bits [1:0].
- fetch_count  out  32  instructions latched into IF/ID (id_valid set).
- flush_count  out  32  redirects taken.

Behaviour:
- Reset (rst=1 at edge) values: pc=RESET_PC, id_instr=NOP_WORD, id_pc4=0, id_valid=0, pc_misalign=0, fetch_count=0, flush_count=0. Reset overrides every other input.
- A redirect is taken when redir_valid=1 and s_npc!=N_nPC. redir_valid=1 with s_npc=N_nPC is no redirect.
- Target computation (combinational, 32-bit, wraps mod 2^32):
  - J_nPC: {redir_pc4[31:28], instr_index, 2'b00}.
  - BEQ_nPC: redir_pc4 + sign_extend(imm16)<<2, i.e. {{14{imm16[15]}}, imm16, 2'b00}.
  - JR_nPC: {jr_target[31:2], 2'b00}; if jr_target[1:0]!=0, pc_misalign sets at the edge and stays set until rst.
- Priority per edge: rst > redirect > stall > normal.
- Redirect (wins over stall):
  - pc<=target.
  - IF/ID squashed: id_instr<=NOP_WORD, id_valid<=0, id_pc4<=0.
  - flush_count+=1.
  - Redirect latency: target appears on imem_addr the cycle after redir_valid; the wrong-path fetch is one instruction, no delay slot.
- Stall (no redirect): pc, id_instr, id_pc4, id_valid and both counters hold.
- Normal: pc<=pc+4; id_instr<=imem_rdata; id_pc4<=pc+4; id_valid<=1; fetch_count+=1.
- Counters wrap 32'hFFFF_FFFF -> 0 silently.
- PC increment wraps 32'hFFFF_FFFC -> 0.
- rst mid-stall or mid-redirect: reset values apply next cycle; pending redirect discarded.

Test Plan:
- Reset then 3 free-run cycles -> imem_addr 0x3000, 0x3004, 0x3008, 0x300C; id_pc4 0x3004, 0x3008, 0x300C; fetch_count=3; id_valid=1 from the second cycle.
- J with redir_pc4=0x0000_3010, instr_index=26'h0000C10 -> next imem_addr=0x0000_3040; id_valid=0, id_instr=0 for one cycle; flush_count=1.
- BEQ backward: redir_pc4=0x3020, imm16=16'hFFFC -> imem_addr=0x3010. BEQ forward: imm16=16'h0003 -> imem_addr=0x302C.
- JR with jr_target=0x0000_4006 -> imem_addr=0x4004 and pc_misalign=1, still set 10 cycles later. Repeat with jr_target=0x4008 after rst -> pc_misalign stays 0.
- stall=1 for 2 cycles at pc=0x3008 -> imem_addr, id_instr and fetch_count frozen. Same cycle stall=1 + J redirect -> redirect taken, IF/ID squashed.
- Assert rst during a redirect cycle -> imem_addr=0x3000 next cycle, flush_count=0, id_valid=0.
